// File: rtl/spm_arbiter.sv
// spm_arbiter: shares the single-port data scratchpad between the CPU memory
// stage and an external bus master (debug/DMA).
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata/byteena  CPU access request and payload
//   cpu_gnt, cpu_stall             CPU grant (same cycle) and pipeline stall
//   cpu_rvalid                     CPU read data valid (cycle after grant)
//   ext_req/we/addr/wdata/byteena  external access request and payload
//   ext_lock                       external master asks to keep ownership
//   ext_gnt, ext_rvalid            external grant and read data valid
//   spm_rd_data, rd_data           SPM read data in, shared read data out
//   spm_cs/we/addr/wr_data/byteena SPM macro controls, muxed from the winner
//
// The CPU wins by default. A starvation counter forces the external port to
// win after STARVE_LIMIT consecutive denied cycles, and ext_lock lets the
// external master hold the SPM for at most LOCK_MAX consecutive grants.
module spm_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned LOCK_MAX     = 8
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byteena,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic        cpu_rvalid,

    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic [3:0]  ext_byteena,
    input  logic        ext_lock,
    output logic        ext_gnt,
    output logic        ext_rvalid,

    input  logic [31:0] spm_rd_data,
    output logic [31:0] rd_data,

    output logic        spm_cs,
    output logic        spm_we,
    output logic [31:0] spm_addr,
    output logic [31:0] spm_wr_data,
    output logic [3:0]  spm_byteena
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [CNT_W-1:0] STARVE_LIM_C = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LOCK_MAX_C   = CNT_W'(LOCK_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT_C    = CNT_W'(CNT_MAX);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_EXT  = 2'd2
    } owner_t;

    owner_t            owner;
    owner_t            owner_nxt;
    logic [CNT_W-1:0]  starve_cnt;
    logic [CNT_W-1:0]  starve_cnt_nxt;
    logic [CNT_W-1:0]  lock_cnt;
    logic [CNT_W-1:0]  lock_cnt_nxt;
    logic              lock_prev;
    logic              lock_prev_nxt;
    logic              force_ext;
    logic              lock_ext;

    // Owner, counters, lock flag and read-valid registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= OWN_IDLE;
            starve_cnt <= '0;
            lock_cnt   <= '0;
            lock_prev  <= 1'b0;
            cpu_rvalid <= 1'b0;
            ext_rvalid <= 1'b0;
        end else begin
            owner      <= owner_nxt;
            starve_cnt <= starve_cnt_nxt;
            lock_cnt   <= lock_cnt_nxt;
            lock_prev  <= lock_prev_nxt;
            cpu_rvalid <= cpu_gnt & ~cpu_we;
            ext_rvalid <= ext_gnt & ~ext_we;
        end
    end

    // Grant decision and next-state for owner and counters
    always_comb begin
        owner_nxt      = OWN_IDLE;
        cpu_gnt        = 1'b0;
        ext_gnt        = 1'b0;
        starve_cnt_nxt = '0;
        lock_cnt_nxt   = '0;
        lock_prev_nxt  = lock_prev;

        force_ext = ext_req && (starve_cnt == STARVE_LIM_C);
        lock_ext  = ext_req && (owner == OWN_EXT) && lock_prev &&
                    (lock_cnt < LOCK_MAX_C);

        // Starvation and lock overrides both pick EXT; otherwise CPU first
        if (force_ext || lock_ext) begin
            ext_gnt   = 1'b1;
            owner_nxt = OWN_EXT;
        end else if (cpu_req) begin
            cpu_gnt   = 1'b1;
            owner_nxt = OWN_CPU;
        end else if (ext_req) begin
            ext_gnt   = 1'b1;
            owner_nxt = OWN_EXT;
        end

        // Count consecutive denied external cycles, holding at the limit
        if (ext_req && !ext_gnt) begin
            if (starve_cnt == STARVE_LIM_C) begin
                starve_cnt_nxt = starve_cnt;
            end else begin
                starve_cnt_nxt = starve_cnt + CNT_W'(1);
            end
        end

        // Burst length; saturates so an unlocked run of EXT grants cannot wrap
        if (ext_gnt) begin
            if (owner != OWN_EXT) begin
                lock_cnt_nxt = CNT_W'(1);
            end else if (lock_cnt == CNT_SAT_C) begin
                lock_cnt_nxt = lock_cnt;
            end else begin
                lock_cnt_nxt = lock_cnt + CNT_W'(1);
            end
        end

        // Lock request is sampled only on cycles where somebody is granted
        if (ext_gnt) begin
            lock_prev_nxt = ext_lock;
        end else if (cpu_gnt) begin
            lock_prev_nxt = 1'b0;
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign rd_data   = spm_rd_data;
    assign spm_cs    = cpu_gnt | ext_gnt;

    // SPM payload from the winning port, zero when idle
    always_comb begin
        spm_we      = 1'b0;
        spm_addr    = '0;
        spm_wr_data = '0;
        spm_byteena = '0;
        if (cpu_gnt) begin
            spm_we      = cpu_we;
            spm_addr    = cpu_addr;
            spm_wr_data = cpu_wdata;
            spm_byteena = cpu_byteena;
        end else if (ext_gnt) begin
            spm_we      = ext_we;
            spm_addr    = ext_addr;
            spm_wr_data = ext_wdata;
            spm_byteena = ext_byteena;
        end
    end

endmodule
